// File: rtl/dbg_dm_arb.sv
// Data-memory/IO bus arbiter between the AVR core and the debug engine.
// Core has default priority; a starvation counter forces debug through, and wait-stretched accesses stay locked to their owner.
module dbg_dm_arb #(
    parameter int unsigned starve_lim = 8,
    parameter int unsigned cnt_w      = 4
) (
    input  logic             cp2,
    input  logic             ireset,
    input  logic [15:0]      c_ramadr,
    input  logic             c_ramre,
    input  logic             c_ramwe,
    input  logic [7:0]       c_dbusout,
    output logic [7:0]       c_dbusin,
    output logic             c_ramwait,
    input  logic [15:0]      d_ramadr,
    input  logic             d_ramre,
    input  logic             d_ramwe,
    input  logic [7:0]       d_dm_dbusout,
    output logic [7:0]       d_dm_dbusin,
    output logic             d_ramwait,
    output logic [15:0]      s_ramadr,
    output logic             s_ramre,
    output logic             s_ramwe,
    output logic [7:0]       s_dbusout,
    input  logic [7:0]       s_dbusin,
    input  logic             s_ramwait,
    output logic             dbg_gnt,
    output logic [cnt_w-1:0] starve_cnt
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOCK_C, ST_LOCK_D} st_t;
    typedef enum logic [1:0] {SEL_NONE, SEL_CORE, SEL_DBG} sel_t;

    localparam logic [cnt_w-1:0] LIM = cnt_w'(starve_lim);

    st_t              r_st;
    st_t              w_st_nxt;
    logic [cnt_w-1:0] r_starve_cnt;
    logic [cnt_w-1:0] w_cnt_nxt;
    sel_t             w_sel;
    logic             w_req_c;
    logic             w_req_d;

    assign w_req_c    = c_ramre | c_ramwe;
    assign w_req_d    = d_ramre | d_ramwe;
    assign starve_cnt = r_starve_cnt;

    // State register
    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
            r_st         <= ST_IDLE;
            r_starve_cnt <= '0;
        end else begin
            r_st         <= w_st_nxt;
            r_starve_cnt <= w_cnt_nxt;
        end
    end

    // Next state and starvation count
    always_comb begin
        w_st_nxt  = ST_IDLE;
        w_cnt_nxt = r_starve_cnt;
        if (w_sel == SEL_CORE && s_ramwait) begin
            w_st_nxt = ST_LOCK_C;
        end else if (w_sel == SEL_DBG && s_ramwait) begin
            w_st_nxt = ST_LOCK_D;
        end

        if (!w_req_d || (w_sel == SEL_DBG && !s_ramwait)) begin
            w_cnt_nxt = '0;
        end else if (w_sel != SEL_DBG && r_starve_cnt != LIM) begin
            w_cnt_nxt = r_starve_cnt + cnt_w'(1);
        end
    end

    // Selection and bus steering; a lock keeps its owner even if strobes drop
    always_comb begin
        w_sel       = SEL_NONE;
        s_ramadr    = '0;
        s_ramre     = 1'b0;
        s_ramwe     = 1'b0;
        s_dbusout   = '0;
        c_dbusin    = '0;
        d_dm_dbusin = '0;
        c_ramwait   = w_req_c;
        d_ramwait   = w_req_d;

        case (r_st)
            ST_LOCK_C: w_sel = SEL_CORE;
            ST_LOCK_D: w_sel = SEL_DBG;
            default: begin
                if (w_req_d && (!w_req_c || r_starve_cnt == LIM)) begin
                    w_sel = SEL_DBG;
                end else if (w_req_c) begin
                    w_sel = SEL_CORE;
                end
            end
        endcase

        case (w_sel)
            SEL_CORE: begin
                s_ramadr  = c_ramadr;
                s_ramre   = c_ramre;
                s_ramwe   = c_ramwe;
                s_dbusout = c_dbusout;
                c_dbusin  = s_dbusin;
                c_ramwait = s_ramwait;
            end
            SEL_DBG: begin
                s_ramadr    = d_ramadr;
                s_ramre     = d_ramre;
                s_ramwe     = d_ramwe;
                s_dbusout   = d_dm_dbusout;
                d_dm_dbusin = s_dbusin;
                d_ramwait   = s_ramwait;
            end
            default: ;
        endcase

        dbg_gnt = (w_sel == SEL_DBG);
    end

endmodule

// File: tb/tb_dbg_dm_arb.sv
// Directed bench for dbg_dm_arb: idle, single-master accesses, starvation, lock and reset mid-access.
module tb_dbg_dm_arb;

    logic        cp2 = 1'b0;
    logic        ireset;
    logic [15:0] c_ramadr, d_ramadr, s_ramadr;
    logic        c_ramre, c_ramwe, d_ramre, d_ramwe;
    logic [7:0]  c_dbusout, c_dbusin, d_dm_dbusout, d_dm_dbusin, s_dbusout, s_dbusin;
    logic        c_ramwait, d_ramwait, s_ramre, s_ramwe, s_ramwait, dbg_gnt;
    logic [3:0]  starve_cnt;

    int checks   = 0;
    int failures = 0;

    dbg_dm_arb #(.starve_lim(8), .cnt_w(4)) dut (
        .cp2(cp2), .ireset(ireset),
        .c_ramadr(c_ramadr), .c_ramre(c_ramre), .c_ramwe(c_ramwe),
        .c_dbusout(c_dbusout), .c_dbusin(c_dbusin), .c_ramwait(c_ramwait),
        .d_ramadr(d_ramadr), .d_ramre(d_ramre), .d_ramwe(d_ramwe),
        .d_dm_dbusout(d_dm_dbusout), .d_dm_dbusin(d_dm_dbusin), .d_ramwait(d_ramwait),
        .s_ramadr(s_ramadr), .s_ramre(s_ramre), .s_ramwe(s_ramwe),
        .s_dbusout(s_dbusout), .s_dbusin(s_dbusin), .s_ramwait(s_ramwait),
        .dbg_gnt(dbg_gnt), .starve_cnt(starve_cnt)
    );

    always #5 cp2 = ~cp2;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge cp2);
        #1;
    endtask

    task automatic smp();
        @(negedge cp2);
    endtask

    initial begin
        ireset = 1'b0;
        c_ramadr = '0; c_ramre = 0; c_ramwe = 0; c_dbusout = '0;
        d_ramadr = '0; d_ramre = 0; d_ramwe = 0; d_dm_dbusout = '0;
        s_dbusin = '0; s_ramwait = 0;

        // Idle bus under and after reset
        smp();
        chk("rst_cnt", 16'(starve_cnt), 16'h0);
        chk("rst_gnt", 16'(dbg_gnt), 16'h0);
        nxt(); ireset = 1'b1;
        smp();
        chk("idle_adr", s_ramadr, 16'h0);
        chk("idle_re_we", {14'h0, s_ramre, s_ramwe}, 16'h0);
        chk("idle_dout", 16'(s_dbusout), 16'h0);
        chk("idle_waits", {14'h0, c_ramwait, d_ramwait}, 16'h0);
        chk("idle_cnt", 16'(starve_cnt), 16'h0);

        // Core read alone
        nxt(); c_ramadr = 16'h0060; c_ramre = 1; s_dbusin = 8'hA5;
        smp();
        chk("cr_adr", s_ramadr, 16'h0060);
        chk("cr_re", 16'(s_ramre), 16'h1);
        chk("cr_din", 16'(c_dbusin), 16'h00A5);
        chk("cr_wait", 16'(c_ramwait), 16'h0);
        chk("cr_gnt", 16'(dbg_gnt), 16'h0);

        // Debug write alone
        nxt(); c_ramre = 0; d_ramadr = 16'h0100; d_ramwe = 1; d_dm_dbusout = 8'h55; s_dbusin = 8'h3C;
        smp();
        chk("dw_adr", s_ramadr, 16'h0100);
        chk("dw_we", 16'(s_ramwe), 16'h1);
        chk("dw_dout", 16'(s_dbusout), 16'h0055);
        chk("dw_gnt", 16'(dbg_gnt), 16'h1);
        chk("dw_wait", 16'(d_ramwait), 16'h0);
        chk("dw_ddin", 16'(d_dm_dbusin), 16'h003C);
        chk("dw_cdin", 16'(c_dbusin), 16'h0);

        // Starvation: core holds the bus for 8 cycles, debug forced on the 9th
        nxt(); d_ramwe = 0; d_ramadr = 16'h0300; d_ramre = 1;
        c_ramadr = 16'h0200; c_ramre = 1; s_dbusin = 8'h77;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) nxt();
            smp();
            chk("stv_cnt", 16'(starve_cnt), 16'(i));
            chk("stv_gnt", 16'(dbg_gnt), 16'h0);
            chk("stv_dwait", 16'(d_ramwait), 16'h1);
            chk("stv_adr", s_ramadr, 16'h0200);
            chk("stv_cdin", 16'(c_dbusin), 16'h0077);
        end
        nxt(); smp();
        chk("force_cnt", 16'(starve_cnt), 16'h8);
        chk("force_gnt", 16'(dbg_gnt), 16'h1);
        chk("force_cwait", 16'(c_ramwait), 16'h1);
        chk("force_dwait", 16'(d_ramwait), 16'h0);
        chk("force_adr", s_ramadr, 16'h0300);
        chk("force_ddin", 16'(d_dm_dbusin), 16'h0077);
        nxt(); d_ramre = 0;
        smp();
        chk("after_cnt", 16'(starve_cnt), 16'h0);
        chk("after_gnt", 16'(dbg_gnt), 16'h0);
        chk("after_cwait", 16'(c_ramwait), 16'h0);

        // Build up count, then a wait-stretched core access locks the bus
        nxt(); d_ramre = 1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) nxt();
            smp();
            chk("pre_cnt", 16'(starve_cnt), 16'(k));
        end
        nxt(); s_ramwait = 1;
        smp();
        chk("lk0_cnt", 16'(starve_cnt), 16'h5);
        chk("lk0_waits", {14'h0, c_ramwait, d_ramwait}, 16'h3);
        chk("lk0_gnt", 16'(dbg_gnt), 16'h0);
        nxt(); smp();
        chk("lk1_cnt", 16'(starve_cnt), 16'h6);
        chk("lk1_adr", s_ramadr, 16'h0200);
        chk("lk1_cwait", 16'(c_ramwait), 16'h1);
        nxt(); smp();
        chk("lk2_cnt", 16'(starve_cnt), 16'h7);
        chk("lk2_gnt", 16'(dbg_gnt), 16'h0);
        nxt(); s_ramwait = 0;
        smp();
        chk("lkend_cnt", 16'(starve_cnt), 16'h8);
        chk("lkend_waits", {14'h0, c_ramwait, d_ramwait}, 16'h1);
        chk("lkend_gnt", 16'(dbg_gnt), 16'h0);

        // Forced debug grant enters a stretched access
        nxt(); s_ramwait = 1;
        smp();
        chk("dg_gnt", 16'(dbg_gnt), 16'h1);
        chk("dg_adr", s_ramadr, 16'h0300);
        chk("dg_waits", {14'h0, c_ramwait, d_ramwait}, 16'h3);
        chk("dg_cnt", 16'(starve_cnt), 16'h8);

        // Debug drops its strobe while locked: lock and count hold
        nxt(); d_ramre = 0;
        smp();
        chk("ld_gnt", 16'(dbg_gnt), 16'h1);
        chk("ld_cnt", 16'(starve_cnt), 16'h8);
        chk("ld_re", 16'(s_ramre), 16'h0);
        chk("ld_adr", s_ramadr, 16'h0300);
        chk("ld_cwait", 16'(c_ramwait), 16'h1);

        // Asynchronous reset mid-lock
        #1 ireset = 0;
        #1;
        chk("ar_gnt", 16'(dbg_gnt), 16'h0);
        chk("ar_cnt", 16'(starve_cnt), 16'h0);
        chk("ar_adr", s_ramadr, 16'h0200);
        nxt(); ireset = 1; s_ramwait = 0; d_ramre = 1;
        smp();
        chk("rr_gnt", 16'(dbg_gnt), 16'h0);
        chk("rr_adr", s_ramadr, 16'h0200);
        chk("rr_waits", {14'h0, c_ramwait, d_ramwait}, 16'h1);
        nxt(); smp();
        chk("rr_cnt", 16'(starve_cnt), 16'h1);

        // Back to idle
        nxt(); c_ramre = 0; d_ramre = 0;
        smp();
        chk("end_adr", s_ramadr, 16'h0);
        chk("end_waits", {14'h0, c_ramwait, d_ramwait}, 16'h0);
        nxt(); smp();
        chk("end_cnt", 16'(starve_cnt), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
